// File: rtl/sent_tx_frame_seq.sv
// SENT transmit frame sequencer.
// Walks SYNC, STATUS, N x DATA, CRC and an optional PAUSE, and hands one symbol
// at a time to the pulse generator over a valid/done handshake. The serial
// message bits ride in the status nibble. The CRC-4 is computed from the
// latched frame data.
module sent_tx_frame_seq #(
  parameter int MAX_NIBBLES = 6,
  parameter int NIB_CNT_W   = 3,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                     clk_tx,
  input  logic                     reset_n_tx,
  input  logic                     enable_i,
  input  logic                     channel_format_i,
  input  logic                     pause_en_i,
  input  logic [NIB_CNT_W-1:0]     nibble_count_i,
  input  logic [1:0]               status_i,
  input  logic [4*MAX_NIBBLES-1:0] data_i,
  input  logic                     data_valid_i,
  output logic                     data_ready_o,
  input  logic [15:0]              short_msg_i,
  input  logic [17:0]              enh_bit2_i,
  input  logic [17:0]              enh_bit3_i,
  output logic                     sym_valid_o,
  output logic [2:0]               sym_type_o,
  output logic [3:0]               data_nibble_o,
  input  logic                     pulse_done_i,
  output logic                     frame_done_o,
  output logic                     msg_done_o,
  output logic                     busy_o,
  output logic [FRAME_CNT_W-1:0]   frame_cnt_o
);

  localparam int IDX_W = $clog2(MAX_NIBBLES + 1);
  localparam int DW    = 4 * MAX_NIBBLES;

  localparam logic [2:0] SYM_SYNC   = 3'd0;
  localparam logic [2:0] SYM_STATUS = 3'd1;
  localparam logic [2:0] SYM_DATA   = 3'd2;
  localparam logic [2:0] SYM_CRC    = 3'd3;
  localparam logic [2:0] SYM_PAUSE  = 3'd4;

  typedef enum logic [2:0] {IDLE, SYNC, STATUS, DATA, CRC, PAUSE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] n_q;
  logic             fmt_q;
  logic             pause_q;
  logic [DW-1:0]    data_q;
  logic [15:0]      short_q;
  logic [17:0]      enh2_q;
  logic [17:0]      enh3_q;
  logic [4:0]       k_q;

  logic             accept;
  logic             frame_end;
  logic             sync_entry;
  logic             msg_latch;
  logic             k_wrap;
  logic [4:0]       k_next;
  logic [IDX_W-1:0] n_eff;
  logic [IDX_W-1:0] nxt_idx;
  logic [DW-1:0]    data_sh;
  logic [3:0]       nxt_nib;
  logic [15:0]      short_sh;
  logic [17:0]      enh2_sh;
  logic [17:0]      enh3_sh;
  logic [3:0]       status_nib;

  // CRC-4 (x^4+x^3+x^2+1, seed 0101) over n data nibbles plus one zero nibble
  function automatic logic [3:0] crc_calc(input logic [DW-1:0] d, input logic [IDX_W-1:0] n);
    logic [3:0]    c;
    logic [3:0]    nib;
    logic [DW-1:0] sh;
    logic          fb;
    c  = 4'b0101;
    sh = d;
    for (int i = 0; i <= MAX_NIBBLES; i++) begin
      nib = (i < int'(n)) ? sh[DW-1 -: 4] : 4'h0;
      sh  = sh << 4;
      if (i <= int'(n)) begin
        for (int b = 3; b >= 0; b--) begin
          fb = c[3] ^ nib[b];
          c  = {c[2:0], 1'b0};
          if (fb) c = c ^ 4'b1101;
        end
      end
    end
    return c;
  endfunction

  // Handshake decode, frame boundaries, nibble clamp and next-symbol values
  always_comb begin
    accept     = sym_valid_o & pulse_done_i;
    frame_end  = accept & (((state_q == CRC) & ~pause_q) | (state_q == PAUSE));
    sync_entry = enable_i & ((state_q == IDLE) | frame_end);
    k_wrap     = (k_q >= (fmt_q ? 5'd17 : 5'd15));
    k_next     = k_wrap ? 5'd0 : k_q + 5'd1;
    msg_latch  = sync_entry & ((state_q == IDLE) | (k_next == 5'd0));

    if (nibble_count_i == '0)
      n_eff = IDX_W'(1);
    else if (int'(nibble_count_i) > MAX_NIBBLES)
      n_eff = IDX_W'(MAX_NIBBLES);
    else
      n_eff = IDX_W'(nibble_count_i);

    nxt_idx = (state_q == DATA) ? idx_q + IDX_W'(1) : '0;
    data_sh = data_q << {nxt_idx, 2'b00};
    nxt_nib = data_sh[DW-1 -: 4];

    short_sh   = short_q << k_q;
    enh2_sh    = enh2_q << k_q;
    enh3_sh    = enh3_q << k_q;
    status_nib = {fmt_q ? enh3_sh[17] : (k_q == 5'd0),
                  fmt_q ? enh2_sh[17] : short_sh[15],
                  status_i};
  end

  // Frame sequencer: state, latched frame setup and all registered outputs
  always_ff @(posedge clk_tx) begin
    if (!reset_n_tx) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      n_q           <= '0;
      fmt_q         <= 1'b0;
      pause_q       <= 1'b0;
      data_q        <= '0;
      short_q       <= '0;
      enh2_q        <= '0;
      enh3_q        <= '0;
      k_q           <= '0;
      data_ready_o  <= 1'b0;
      sym_valid_o   <= 1'b0;
      sym_type_o    <= SYM_SYNC;
      data_nibble_o <= '0;
      frame_done_o  <= 1'b0;
      msg_done_o    <= 1'b0;
      busy_o        <= 1'b0;
      frame_cnt_o   <= '0;
    end else begin
      data_ready_o <= 1'b0;
      frame_done_o <= 1'b0;
      msg_done_o   <= 1'b0;

      if (data_ready_o && data_valid_i) data_q <= data_i;

      if (sync_entry) begin
        n_q          <= n_eff;
        fmt_q        <= channel_format_i;
        pause_q      <= pause_en_i;
        data_ready_o <= 1'b1;
        if (msg_latch) begin
          short_q <= short_msg_i;
          enh2_q  <= enh_bit2_i;
          enh3_q  <= enh_bit3_i;
        end
      end

      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q       <= SYNC;
            sym_valid_o   <= 1'b1;
            busy_o        <= 1'b1;
            sym_type_o    <= SYM_SYNC;
            data_nibble_o <= '0;
          end
        end
        SYNC: begin
          if (accept) begin
            state_q       <= STATUS;
            sym_type_o    <= SYM_STATUS;
            data_nibble_o <= status_nib;
          end
        end
        STATUS: begin
          if (accept) begin
            state_q       <= DATA;
            idx_q         <= nxt_idx;
            sym_type_o    <= SYM_DATA;
            data_nibble_o <= nxt_nib;
          end
        end
        DATA: begin
          if (accept) begin
            if (idx_q == n_q - IDX_W'(1)) begin
              state_q       <= CRC;
              sym_type_o    <= SYM_CRC;
              data_nibble_o <= crc_calc(data_q, n_q);
            end else begin
              idx_q         <= nxt_idx;
              data_nibble_o <= nxt_nib;
            end
          end
        end
        CRC: begin
          if (accept && pause_q) begin
            state_q       <= PAUSE;
            sym_type_o    <= SYM_PAUSE;
            data_nibble_o <= '0;
          end
        end
        PAUSE: begin
        end
        default: state_q <= IDLE;
      endcase

      if (frame_end) begin
        frame_done_o  <= 1'b1;
        msg_done_o    <= k_wrap;
        frame_cnt_o   <= frame_cnt_o + FRAME_CNT_W'(1);
        sym_type_o    <= SYM_SYNC;
        data_nibble_o <= '0;
        if (enable_i) begin
          state_q <= SYNC;
          k_q     <= k_next;
        end else begin
          state_q     <= IDLE;
          k_q         <= '0;
          sym_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sent_tx_frame_seq.sv
// Self-checking bench for sent_tx_frame_seq: a table of single-frame vectors
// plus hand-written multi-frame sequences (back-to-back, serial messages,
// pause, stall, reset abort, frame counter wrap).
module tb_sent_tx_frame_seq;

  logic        clk_tx = 1'b0;
  logic        reset_n_tx;
  logic        enable_i;
  logic        channel_format_i;
  logic        pause_en_i;
  logic [2:0]  nibble_count_i;
  logic [1:0]  status_i;
  logic [23:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [15:0] short_msg_i;
  logic [17:0] enh_bit2_i;
  logic [17:0] enh_bit3_i;
  logic        sym_valid_o;
  logic [2:0]  sym_type_o;
  logic [3:0]  data_nibble_o;
  logic        pulse_done_i;
  logic        frame_done_o;
  logic        msg_done_o;
  logic        busy_o;
  logic [7:0]  frame_cnt_o;

  int total = 0;
  int bad   = 0;
  int expFrames = 0;

  sent_tx_frame_seq #(.MAX_NIBBLES(6), .NIB_CNT_W(3), .FRAME_CNT_W(8)) dut (
    .clk_tx(clk_tx), .reset_n_tx(reset_n_tx), .enable_i(enable_i),
    .channel_format_i(channel_format_i), .pause_en_i(pause_en_i),
    .nibble_count_i(nibble_count_i), .status_i(status_i), .data_i(data_i),
    .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .short_msg_i(short_msg_i), .enh_bit2_i(enh_bit2_i), .enh_bit3_i(enh_bit3_i),
    .sym_valid_o(sym_valid_o), .sym_type_o(sym_type_o), .data_nibble_o(data_nibble_o),
    .pulse_done_i(pulse_done_i), .frame_done_o(frame_done_o), .msg_done_o(msg_done_o),
    .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_tx = ~clk_tx;

  typedef struct {
    logic [2:0]  nibCnt;
    logic [23:0] data;
    logic        dataValid;
    logic [1:0]  statusIn;
    int          expN;
    logic [23:0] expData;
    logic [3:0]  expStatus;
    logic [3:0]  expCrc;
  } vec_t;

  vec_t vecs[7];

  // Compare one observed value against its expected value
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one table vector and request a frame
  task automatic applyStimulus(input vec_t v);
    nibble_count_i = v.nibCnt;
    data_i         = v.data;
    data_valid_i   = v.dataValid;
    status_i       = v.statusIn;
    enable_i       = 1'b1;
  endtask

  // CRC-4 reference: one table lookup per nibble (equivalent of four zero-bit shifts)
  function automatic logic [3:0] tStep(input logic [3:0] x);
    return (x[3] ? 4'h1 : 4'h0) ^ (x[2] ? 4'hE : 4'h0) ^ (x[1] ? 4'h7 : 4'h0) ^ (x[0] ? 4'hD : 4'h0);
  endfunction

  function automatic logic [3:0] crcModel(input logic [23:0] d, input int n);
    logic [3:0] c;
    c = 4'h5;
    for (int i = 0; i < n; i++) c = tStep(c ^ d[23-4*i -: 4]);
    return tStep(c);
  endfunction

  function automatic logic [3:0] statusModel(input bit fmt, input int k, input logic [15:0] sm,
                                             input logic [17:0] e2, input logic [17:0] e3,
                                             input logic [1:0] st);
    if (!fmt) return {(k == 0), sm[15-k], st};
    return {e3[17-k], e2[17-k], st};
  endfunction

  // Follow one frame from its SYNC cycle (current negedge) to its frame_done cycle
  task automatic runFrame(input string tag, input logic [3:0] expStatus, input logic [23:0] expData,
                          input int expN, input logic [3:0] expCrc, input bit expPause,
                          input bit keepEnable, input bit expMsgDone, input int stallNib);
    logic [23:0] sh;
    logic [3:0]  cur;
    checkOutput({tag, " sync"}, 32'({sym_valid_o, sym_type_o, data_nibble_o, data_ready_o, busy_o}),
                32'({1'b1, 3'd0, 4'h0, 1'b1, 1'b1}));
    @(negedge clk_tx);
    checkOutput({tag, " status"}, 32'({sym_valid_o, sym_type_o, data_nibble_o, data_ready_o}),
                32'({1'b1, 3'd1, expStatus, 1'b0}));
    if (!keepEnable) enable_i = 1'b0;
    sh = expData;
    for (int i = 0; i < expN; i++) begin
      @(negedge clk_tx);
      cur = sh[23:20];
      sh  = sh << 4;
      checkOutput($sformatf("%s data%0d", tag, i), 32'({sym_valid_o, sym_type_o, data_nibble_o}),
                  32'({1'b1, 3'd2, cur}));
      if (i == stallNib) begin
        pulse_done_i = 1'b0;
        for (int c = 0; c < 50; c++) begin
          @(negedge clk_tx);
          checkOutput($sformatf("%s stall%0d", tag, c),
                      32'({sym_valid_o, sym_type_o, data_nibble_o, busy_o, frame_done_o}),
                      32'({1'b1, 3'd2, cur, 1'b1, 1'b0}));
        end
        pulse_done_i = 1'b1;
      end
    end
    @(negedge clk_tx);
    checkOutput({tag, " crc"}, 32'({sym_valid_o, sym_type_o, data_nibble_o, frame_done_o}),
                32'({1'b1, 3'd3, expCrc, 1'b0}));
    if (expPause) begin
      @(negedge clk_tx);
      checkOutput({tag, " pause"}, 32'({sym_valid_o, sym_type_o, data_nibble_o, frame_done_o}),
                  32'({1'b1, 3'd4, 4'h0, 1'b0}));
    end
    @(negedge clk_tx);
    expFrames = (expFrames + 1) % 256;
    checkOutput({tag, " end"}, 32'({frame_done_o, msg_done_o, sym_valid_o, busy_o}),
                32'({1'b1, expMsgDone, keepEnable, keepEnable}));
    checkOutput({tag, " fcnt"}, 32'(frame_cnt_o), 32'(expFrames));
  endtask

  initial begin
    int nDone;
    int cyc;
    logic [3:0] st;

    vecs[0] = '{3'd1, 24'h000000, 1'b1, 2'd0, 1, 24'h000000, 4'h8, 4'hA};
    vecs[1] = '{3'd6, 24'h123456, 1'b1, 2'd2, 6, 24'h123456, 4'hA, 4'h1};
    vecs[2] = '{3'd1, 24'hF00000, 1'b1, 2'd3, 1, 24'hF00000, 4'hB, 4'h9};
    vecs[3] = '{3'd2, 24'hA50000, 1'b1, 2'd1, 2, 24'hA50000, 4'h9, 4'h0};
    vecs[4] = '{3'd0, 24'h012345, 1'b1, 2'd0, 1, 24'h012345, 4'h8, 4'hA};
    vecs[5] = '{3'd7, 24'h654321, 1'b1, 2'd0, 6, 24'h654321, 4'h8, 4'hE};
    vecs[6] = '{3'd3, 24'hFFFFFF, 1'b0, 2'd0, 3, 24'h654321, 4'h8, 4'h2};

    reset_n_tx = 1'b0; enable_i = 1'b0; channel_format_i = 1'b0; pause_en_i = 1'b0;
    nibble_count_i = 3'd1; status_i = 2'd0; data_i = '0; data_valid_i = 1'b1;
    short_msg_i = '0; enh_bit2_i = '0; enh_bit3_i = '0; pulse_done_i = 1'b1;
    repeat (3) @(posedge clk_tx);
    @(negedge clk_tx);
    checkOutput("reset outs", 32'({sym_valid_o, sym_type_o, data_nibble_o, data_ready_o,
                                   frame_done_o, msg_done_o, busy_o, frame_cnt_o}), 32'd0);
    reset_n_tx = 1'b1;
    @(negedge clk_tx);
    checkOutput("idle busy", 32'({busy_o, sym_valid_o}), 32'd0);

    // Single frames from the vector table
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v]);
      @(negedge clk_tx);
      runFrame($sformatf("vec%0d", v), vecs[v].expStatus, vecs[v].expData, vecs[v].expN,
               vecs[v].expCrc, 1'b0, 1'b0, 1'b0, -1);
    end

    // Back-to-back frames with enable held, stall in the second frame
    data_valid_i = 1'b1; data_i = 24'h123456; nibble_count_i = 3'd6; status_i = 2'd0;
    enable_i = 1'b1;
    @(negedge clk_tx);
    for (int f = 0; f < 3; f++)
      runFrame($sformatf("b2b%0d", f), statusModel(1'b0, f, 16'h0, 18'h0, 18'h0, 2'd0), 24'h123456, 6,
               crcModel(24'h123456, 6), 1'b0, f < 2, 1'b0, (f == 1) ? 2 : -1);

    // Short serial message over 16 frames, then k back at 0
    short_msg_i = 16'hA5C3; data_i = 24'h000000; nibble_count_i = 3'd1;
    enable_i = 1'b1;
    @(negedge clk_tx);
    for (int k = 0; k < 16; k++)
      runFrame($sformatf("short%0d", k), statusModel(1'b0, k, 16'hA5C3, 18'h0, 18'h0, 2'd0), 24'h000000, 1,
               4'hA, 1'b0, k < 15, k == 15, -1);
    enable_i = 1'b1;
    @(negedge clk_tx);
    runFrame("short again", 4'hC, 24'h000000, 1, 4'hA, 1'b0, 1'b0, 1'b0, -1);

    // Enhanced serial message over 18 frames
    channel_format_i = 1'b1; enh_bit3_i = 18'h3F000; enh_bit2_i = 18'h2AAAA;
    status_i = 2'd1; data_i = 24'hA50000; nibble_count_i = 3'd2;
    enable_i = 1'b1;
    @(negedge clk_tx);
    for (int k = 0; k < 18; k++) begin
      st = statusModel(1'b1, k, 16'h0, 18'h2AAAA, 18'h3F000, 2'd1);
      runFrame($sformatf("enh%0d", k), st, 24'hA50000, 2, crcModel(24'hA50000, 2),
               1'b0, k < 17, k == 17, -1);
    end

    // Pause symbol appended after CRC
    pause_en_i = 1'b1;
    enable_i = 1'b1;
    @(negedge clk_tx);
    runFrame("pause", 4'hD, 24'hA50000, 2, 4'h0, 1'b1, 1'b0, 1'b0, -1);
    pause_en_i = 1'b0; channel_format_i = 1'b0;

    // Reset in the middle of a DATA symbol aborts the frame
    data_i = 24'h123456; nibble_count_i = 3'd6; enable_i = 1'b1;
    @(negedge clk_tx);
    repeat (3) @(negedge clk_tx);
    checkOutput("pre-reset data1", 32'({sym_type_o, data_nibble_o}), 32'({3'd2, 4'h2}));
    reset_n_tx = 1'b0; enable_i = 1'b0;
    @(negedge clk_tx);
    checkOutput("mid reset outs", 32'({sym_valid_o, sym_type_o, data_nibble_o, data_ready_o,
                                       frame_done_o, msg_done_o, busy_o, frame_cnt_o}), 32'd0);
    reset_n_tx = 1'b1;
    expFrames = 0;

    // Frame counter wraps 255 -> 0
    nibble_count_i = 3'd1; data_i = 24'h000000; enable_i = 1'b1;
    nDone = 0; cyc = 0;
    while (nDone < 255 && cyc < 3000) begin
      @(negedge clk_tx);
      cyc++;
      if (frame_done_o) nDone++;
    end
    checkOutput("wrap frames", 32'(nDone), 32'd255);
    checkOutput("wrap 255", 32'(frame_cnt_o), 32'd255);
    enable_i = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk_tx);
      cyc++;
    end while (!frame_done_o && cyc < 20);
    checkOutput("wrap zero", 32'({frame_done_o, frame_cnt_o, busy_o}), 32'({1'b1, 8'd0, 1'b0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
